systolic_result_drain: RTL and testbench

//  Output-side companion to the NxN systolic matrix multiplier (top_level_file).

---
 rtl/systolic_pkg.sv | 18 +
 rtl/systolic_result_drain_counter.sv | 45 ++++
 rtl/systolic_result_drain.sv | 105 ++++++++++
 tb/tb_systolic_result_drain.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic matrix multiplier
// and its result drain.
package systolic_pkg;

  localparam int N            = 3;
  localparam int DATA_WIDTH   = 8;
  localparam int OUTPUT_WIDTH = 16;
  localparam int IDX_WIDTH    = (N > 1) ? $clog2(N) : 1;

  typedef logic [OUTPUT_WIDTH-1:0] result_t;
  typedef logic [IDX_WIDTH-1:0]    idx_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } drain_state_e;

endpackage

// File: rtl/systolic_result_drain_counter.sv
// Row-major row/col walker for the result drain: enable,
// synchronous load-to-zero, and a flag on the final element.
module drain_index_counter
  import systolic_pkg::*;
#(
  parameter int N         = systolic_pkg::N,
  parameter int IDX_WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  output logic [IDX_WIDTH-1:0] row,
  output logic [IDX_WIDTH-1:0] col,
  output logic                 last
);

  localparam logic [IDX_WIDTH-1:0] MAX = IDX_WIDTH'(N - 1);
  localparam logic [IDX_WIDTH-1:0] ONE = IDX_WIDTH'(1);

  logic col_wrap;
  logic row_wrap;

  assign col_wrap = (col == MAX);
  assign row_wrap = (row == MAX);
  assign last     = col_wrap && row_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col <= '0;
        row <= row_wrap ? '0 : row + ONE;
      end else begin
        col <= col + ONE;
      end
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures the systolic result matrix and streams it row-major
// on a valid/ready port; a result arriving mid-drain is dropped.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int N            = systolic_pkg::N,
  parameter int OUTPUT_WIDTH = systolic_pkg::OUTPUT_WIDTH,
  parameter int IDX_WIDTH    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OUTPUT_WIDTH-1:0] c [0:N-1][0:N-1],
  input  logic                    valid_bit_out,
  output logic [OUTPUT_WIDTH-1:0] m_data,
  output logic [IDX_WIDTH-1:0]    m_row,
  output logic [IDX_WIDTH-1:0]    m_col,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    clr_overrun
);

  drain_state_e state;
  drain_state_e state_nx;

  logic [OUTPUT_WIDTH-1:0] mat_buf [0:N-1][0:N-1];

  logic [IDX_WIDTH-1:0] row;
  logic [IDX_WIDTH-1:0] col;
  logic                 idx_last;
  logic                 xfer;
  logic                 last_xfer;
  logic                 capture;
  logic                 drop;

  assign xfer      = (state == DRAIN) && m_ready;
  assign last_xfer = xfer && idx_last;

  // A new result is only taken when the buffer is free by the
  // next edge: idle, or the final beat leaves this cycle.
  assign capture = valid_bit_out &&
                   ((state == IDLE) || last_xfer);
  assign drop    = valid_bit_out &&
                   (state == DRAIN) && !last_xfer;

  drain_index_counter #(
    .N         (N),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (xfer),
    .clr   (capture),
    .row   (row),
    .col   (col),
    .last  (idx_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE: begin
        if (capture) state_nx = DRAIN;
      end
      state == DRAIN: begin
        if (last_xfer && !capture) state_nx = IDLE;
      end
    endcase
  end

  // Contents are only meaningful while draining; no reset needed.
  always_ff @(posedge clk) begin
    if (capture) begin
      mat_buf <= c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign busy    = (state == DRAIN);
  assign m_valid = busy;
  assign m_data  = busy ? mat_buf[row][col] : '0;
  assign m_row   = row;
  assign m_col   = col;
  assign m_last  = busy && idx_last;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized self-checking bench for systolic_result_drain.
// Expected beats come from a queue filled per accepted matrix.
module tb_systolic_result_drain;

  localparam int NN = 3;

  typedef logic [15:0] mat_t [0:NN-1][0:NN-1];

  typedef struct {
    logic [15:0] d;
    int          r;
    int          c;
    bit          l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  mat_t        c;
  logic        valid_bit_out;
  logic [15:0] m_data;
  logic [1:0]  m_row;
  logic [1:0]  m_col;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        overrun;
  logic        clr_overrun;

  int    n_total = 0;
  int    n_pass  = 0;
  int    nbeats  = 0;
  int    rmode   = 0;
  int    ph      = 0;
  beat_t q [$];

  systolic_result_drain dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .c             (c),
    .valid_bit_out (valid_bit_out),
    .m_data        (m_data),
    .m_row         (m_row),
    .m_col         (m_col),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .busy          (busy),
    .overrun       (overrun),
    .clr_overrun   (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // ready pattern: 0 always, 1 = 1,0,0 repeating, 2 random
  always @(posedge clk) begin
    #1;
    case (rmode)
      1: begin
        m_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end
      2: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b1;
    endcase
  end

  logic        stall_prev = 1'b0;
  logic [15:0] h_data;
  logic [3:0]  h_rc;
  logic        h_last;

  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (stall_prev) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(h_data));
        chk("hold_rowcol", 32'({m_row, m_col}), 32'(h_rc));
        chk("hold_last", 32'(m_last), 32'(h_last));
      end
      stall_prev = m_valid && !m_ready;
      h_data = m_data;
      h_rc   = {m_row, m_col};
      h_last = m_last;
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("spurious_beat", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("beat_data", 32'(m_data), 32'(e.d));
          chk("beat_row", 32'(m_row), 32'(e.r));
          chk("beat_col", 32'(m_col), 32'(e.c));
          chk("beat_last", 32'(m_last), 32'(e.l));
        end
        nbeats++;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_mat(input mat_t m);
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < NN; j++)
        q.push_back('{m[i][j], i, j,
                      (i == NN - 1) && (j == NN - 1)});
  endtask

  // Called at posedge+1; returns at posedge+1 after the pulse.
  task automatic send(input mat_t m, input bit accept,
                      input bit clr = 1'b0);
    c = m;
    valid_bit_out = 1'b1;
    clr_overrun = clr;
    if (accept) push_mat(m);
    @(posedge clk);
    #1;
    valid_bit_out = 1'b0;
    clr_overrun = 1'b0;
  endtask

  task automatic wait_drain(output int cyc);
    cyc = 0;
    while (q.size() != 0 && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    chk("idle_after_drain", 32'(busy), 32'd0);
  endtask

  task automatic wait_beats(input int n);
    int cyc = 0;
    while (nbeats < n && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (nbeats < n) chk("beat_timeout", 32'(nbeats), 32'(n));
  endtask

  task automatic pulse_clr();
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
  endtask

  function automatic mat_t rand_mat();
    mat_t m;
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < NN; j++)
        m[i][j] = 16'($urandom);
    return m;
  endfunction

  function automatic mat_t seq_mat();
    mat_t m;
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < NN; j++)
        m[i][j] = 16'(i * NN + j + 1);
    return m;
  endfunction

  function automatic mat_t signed_prod();
    int a [3][3] = '{'{-1, 2, -3}, '{4, -5, 6}, '{-7, 8, -9}};
    int b [3][3] = '{'{-9, 8, -7}, '{6, -5, 4}, '{-3, 2, -1}};
    mat_t m;
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < NN; j++) begin
        int s = 0;
        for (int k = 0; k < NN; k++) s += a[i][k] * b[k][j];
        m[i][j] = 16'(s);
      end
    return m;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   base;
    bit   inj;
    mat_t m;

    rst_n = 1'b0;
    valid_bit_out = 1'b0;
    clr_overrun = 1'b0;
    m_ready = 1'b1;
    c = seq_mat();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_rowcol", 32'({m_row, m_col}), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: basic drain, one beat per cycle
    rmode = 0;
    send(seq_mat(), 1'b1);
    chk("first_beat_valid", 32'(m_valid), 32'd1);
    chk("first_beat_data", 32'(m_data), 32'd1);
    wait_drain(cyc);
    chk("t1_cycles", 32'(cyc), 32'(NN * NN));

    // 2: 1,0,0 ready pattern
    rmode = 1;
    send(seq_mat(), 1'b1);
    wait_drain(cyc);

    // 3: signed products pass unmodified
    rmode = 2;
    send(signed_prod(), 1'b1);
    wait_drain(cyc);

    // 4: overrun mid-drain, then clear rules
    rmode = 0;
    base = nbeats;
    send(seq_mat(), 1'b1);
    wait_beats(base + 3);
    send(rand_mat(), 1'b0);
    chk("overrun_set", 32'(overrun), 32'd1);
    wait_drain(cyc);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    pulse_clr();
    chk("overrun_clr", 32'(overrun), 32'd0);
    base = nbeats;
    send(rand_mat(), 1'b1);
    wait_beats(base + 2);
    send(rand_mat(), 1'b0, 1'b1);
    chk("overrun_set_wins", 32'(overrun), 32'd1);
    wait_drain(cyc);
    pulse_clr();
    chk("overrun_clr2", 32'(overrun), 32'd0);

    // 5: back-to-back capture on the last transfer
    base = nbeats;
    send(seq_mat(), 1'b1);
    wait_beats(base + NN * NN - 1);
    m = rand_mat();
    send(m, 1'b1);
    chk("b2b_valid", 32'(m_valid), 32'd1);
    chk("b2b_rowcol", 32'({m_row, m_col}), 32'd0);
    chk("b2b_data", 32'(m_data), 32'(m[0][0]));
    chk("b2b_overrun", 32'(overrun), 32'd0);
    wait_drain(cyc);

    // 6: asynchronous reset mid-drain
    base = nbeats;
    send(rand_mat(), 1'b1);
    wait_beats(base + 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_last", 32'(m_last), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = nbeats;
    repeat (20) @(posedge clk);
    #1;
    chk("no_beat_after_rst", 32'(nbeats), 32'(base));
    chk("idle_after_rst", 32'(m_valid), 32'd0);
    send(seq_mat(), 1'b1);
    wait_drain(cyc);

    // random matrices, random ready, occasional rogue pulse
    for (int k = 0; k < 12; k++) begin
      rmode = (k % 3 == 0) ? 1 : 2;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(rand_mat(), 1'b1);
      inj = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        wait_beats(nbeats + 2);
        if (q.size() >= 3) begin
          send(rand_mat(), 1'b0);
          inj = 1'b1;
        end
      end
      wait_drain(cyc);
      chk("rand_overrun", 32'(overrun), 32'(inj));
      pulse_clr();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
